// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer
// Prints a DATA_W-bit word as ASCII hex characters, MSB nibble first. It emits
// one character per out_valid/out_ready handshake, toward a UART TX byte
// interface. Leading zeros are always printed, so every word is DATA_W/4
// characters long.
//
// Optional feature: define HEX_STREAM_CRLF_EN to append CR (0x0D) and LF (0x0A)
// after the last nibble. out_last then moves to the LF character.
//
// The outputs are decoded from the state and the shift register. They depend
// only on registered values, so they stay stable while the consumer stalls.
module hex_ascii_streamer #(
    parameter int unsigned DATA_W = 16,  // multiple of 4, at least 4
    parameter int unsigned UPPER  = 0    // 0: a-f, 1: A-F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned NIB   = DATA_W / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

`ifdef HEX_STREAM_CRLF_EN
    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StCr,
        StLf
    } state_e;
`else
    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;
`endif

    state_e            r_state;
    state_e            w_state_d;
    logic [DATA_W-1:0] r_shift;     // remaining nibbles, current one at the top
    logic [DATA_W-1:0] w_shift_d;
    logic [IDX_W-1:0]  r_idx;       // index of the nibble being shown, counts down
    logic [IDX_W-1:0]  w_idx_d;
    logic              r_armed;     // low during and straight after reset
    logic [3:0]        w_nib;

    assign w_nib = r_shift[DATA_W-1 -: 4];

    // Map one nibble to its ASCII hex character.
    function automatic logic [7:0] f_hex(input logic [3:0] i_nib);
        logic [7:0] w_ext;
        w_ext = {4'h0, i_nib};
        if (i_nib < 4'd10) begin
            return 8'h30 + w_ext;
        end
        // Subtract 10 from the letter base so nibble 10 lands on 'a' or 'A'.
        return ((UPPER != 0) ? 8'h37 : 8'h57) + w_ext;
    endfunction

    // Update the state register and datapath. Reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_idx   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_idx   <= w_idx_d;
            r_armed <= 1'b1;
        end
    end

    // Compute the next state and drive the handshake and character outputs.
    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_idx_d   = r_idx;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        busy      = 1'b0;

        unique case (r_state)
            StIdle: begin
                in_ready = r_armed;
                if (in_valid && r_armed) begin
                    w_shift_d = in_data;
                    w_idx_d   = IDX_TOP;
                    w_state_d = StSend;
                end
            end

            StSend: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = f_hex(w_nib);
`ifndef HEX_STREAM_CRLF_EN
                out_last  = (r_idx == '0);
`endif
                if (out_ready) begin
                    if (r_idx == '0) begin
`ifdef HEX_STREAM_CRLF_EN
                        w_state_d = StCr;
`else
                        w_state_d = StIdle;
`endif
                    end else begin
                        w_shift_d = r_shift << 4;
                        w_idx_d   = r_idx - IDX_W'(1);
                    end
                end
            end

`ifdef HEX_STREAM_CRLF_EN
            StCr: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h0D;
                if (out_ready) begin
                    w_state_d = StLf;
                end
            end

            StLf: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h0A;
                out_last  = 1'b1;
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
`endif

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

endmodule
